shutdown_sense_scan: RTL

Parametrised successor to the 8-channel shutdown sense scanner. Drives an external analog mux select across NUM_CH channels and samples the shared shutdown sense pin after a programmable settle time. Latches a per-channel shutdown flag only after FILTER_COUNT consecutive asserted samples, and records the first-faulting channel. Sits between the board's mux/comparator and the shim's safety/status logic.

---
 rtl/shutdown_sense_pkg.sv | 17 +
 rtl/shutdown_sense_chan_filter.sv | 57 +++++
 rtl/shutdown_sense_scan.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/shutdown_sense_pkg.sv
// Shared types and sizing helpers for the shutdown sense scanner.
package shutdown_sense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } scan_state_e;

  localparam int unsigned FILT_W = 4;

  // Settle counter runs 0..cycles-1.
  function automatic int unsigned settle_cnt_w(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/shutdown_sense_chan_filter.sv
// One channel: saturating consecutive-assert counter and sticky latch.
module shutdown_sense_chan_filter
  import shutdown_sense_pkg::*;
#(
  parameter int unsigned FILTER_COUNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic sample_i,
  input  logic conn_i,
  input  logic pin_i,
  output logic latch_o,
  output logic new_o
);

  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_COUNT);

  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              latch_q, latch_d;
  logic              new_d;

  // Clear dominates a coincident latch so no stale pulse escapes.
  always_comb begin
    cnt_d   = cnt_q;
    latch_d = latch_q;
    new_d   = 1'b0;
    if (clr_i) begin
      cnt_d   = '0;
      latch_d = 1'b0;
    end else if (sample_i) begin
      if (conn_i && pin_i) begin
        cnt_d = (cnt_q >= FILT_MAX) ? FILT_MAX : cnt_q + FILT_W'(1);
        if ((cnt_d == FILT_MAX) && !latch_q) begin
          latch_d = 1'b1;
          new_d   = 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      latch_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  assign latch_o = latch_q;
  assign new_o   = new_d;

endmodule

// File: rtl/shutdown_sense_scan.sv
// Scans an external analog mux, filters the shared sense pin per channel,
// and reports sticky shutdown flags plus the first channel to fault.
module shutdown_sense_scan
  import shutdown_sense_pkg::*;
#(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned SEL_W         = $clog2(NUM_CH),
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned FILTER_COUNT  = 3
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              shutdown_sense_en,
  input  logic              shutdown_sense_clear,
  input  logic [NUM_CH-1:0] shutdown_sense_connected,
  input  logic              shutdown_sense_pin,
  output logic [SEL_W-1:0]  shutdown_sense_sel,
  output logic [NUM_CH-1:0] shutdown_sense,
  output logic [SEL_W-1:0]  first_fault_idx,
  output logic              first_fault_valid,
  output logic              fault_pulse,
  output logic              scan_done
);

  localparam int unsigned      CNT_W       = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_CH - 1);

  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("shutdown_sense_scan: SETTLE_CYCLES must be >= 2");
  end
  if ((FILTER_COUNT < 1) || (FILTER_COUNT > 15)) begin : g_bad_filter
    $error("shutdown_sense_scan: FILTER_COUNT must be 1..15");
  end
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("shutdown_sense_scan: NUM_CH must be >= 2");
  end

  scan_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SEL_W-1:0]  sel_q;
  logic              scan_done_q;
  logic              pin_meta_q, pin_s_q;
  logic              fault_pulse_q;
  logic              ff_valid_q;
  logic [SEL_W-1:0]  ff_idx_q;
  logic [NUM_CH-1:0] new_vec;
  logic [NUM_CH-1:0] latch_vec;
  logic              clr_all;
  logic              sample_now;
  logic              any_new;
  logic [SEL_W-1:0]  new_idx;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pin_meta_q <= 1'b0;
      pin_s_q    <= 1'b0;
    end else begin
      pin_meta_q <= shutdown_sense_pin;
      pin_s_q    <= pin_meta_q;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      scan_done_q <= 1'b0;
    end else if (!shutdown_sense_en) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= SETTLE;
          cnt_q   <= '0;
          sel_q   <= '0;
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) state_q <= SAMPLE;
          else                      cnt_q   <= cnt_q + CNT_W'(1);
        end
        SAMPLE: begin
          state_q     <= SETTLE;
          cnt_q       <= '0;
          sel_q       <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
          scan_done_q <= (sel_q == SEL_LAST);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_all    = !shutdown_sense_en || shutdown_sense_clear;
  assign sample_now = shutdown_sense_en && (state_q == SAMPLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    shutdown_sense_chan_filter #(
      .FILTER_COUNT(FILTER_COUNT)
    ) u_filter (
      .clk     (clk),
      .rst_n   (aresetn),
      .clr_i   (clr_all),
      .sample_i(sample_now && (sel_q == SEL_W'(c))),
      .conn_i  (shutdown_sense_connected[c]),
      .pin_i   (pin_s_q),
      .latch_o (latch_vec[c]),
      .new_o   (new_vec[c])
    );
  end

  // Only the selected channel can latch, but pick the lowest index regardless.
  always_comb begin
    any_new = |new_vec;
    new_idx = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (new_vec[i-1]) new_idx = SEL_W'(i - 1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fault_pulse_q <= 1'b0;
      ff_valid_q    <= 1'b0;
      ff_idx_q      <= '0;
    end else if (clr_all) begin
      fault_pulse_q <= 1'b0;
      ff_valid_q    <= 1'b0;
      ff_idx_q      <= '0;
    end else begin
      fault_pulse_q <= any_new;
      if (any_new && !ff_valid_q) begin
        ff_valid_q <= 1'b1;
        ff_idx_q   <= new_idx;
      end
    end
  end

  assign shutdown_sense_sel = sel_q;
  assign shutdown_sense     = latch_vec;
  assign first_fault_idx    = ff_idx_q;
  assign first_fault_valid  = ff_valid_q;
  assign fault_pulse        = fault_pulse_q;
  assign scan_done          = scan_done_q;

endmodule
